// File: rtl/ripemd160_chain_core_if.sv
// -----------------------------------------------------------------------------
// ripemd160_chain_core_if
// Block-in / digest-out bundle for ripemd160_chain_core.
//
// Signals
//   i_valid  : block offered by the producer
//   i_ready  : core idle, a block offered this cycle is taken
//   i_first  : block starts a new message (chain from IV)
//   i_last   : block ends the message (publish digest)
//   i_block  : 512-bit padded message block
//   o_valid  : one-cycle pulse, o_digest holds a finished digest
//   o_digest : 160-bit digest {h0,h1,h2,h3,h4}
//
// Modports
//   master : producer / consumer side (testbench or upstream logic)
//   slave  : the hash core
// -----------------------------------------------------------------------------
interface ripemd160_chain_core_if;
    logic         i_valid;
    logic         i_ready;
    logic         i_first;
    logic         i_last;
    logic [511:0] i_block;
    logic         o_valid;
    logic [159:0] o_digest;

    modport master (
        output i_valid, i_first, i_last, i_block,
        input  i_ready, o_valid, o_digest
    );

    modport slave (
        input  i_valid, i_first, i_last, i_block,
        output i_ready, o_valid, o_digest
    );
endinterface

// File: rtl/ripemd160_chain_core.sv
// -----------------------------------------------------------------------------
// ripemd160_chain_core
// Iterative RIPEMD-160 compression core with message chaining. Both the left
// and right lines run in parallel, UNROLL steps per clock each. A block is
// taken in IDLE, compressed over 80/UNROLL ROUNDS cycles, and the chaining
// value is folded back into H in the single DONE cycle. When the block closes
// a message the new H is published on o_digest with a one-cycle o_valid.
//
// Parameters
//   UNROLL : steps per clock per line, one of 1,2,4,5,8,10,16,20
//
// Ports
//   clk_p_i : sole clock, rising edge
//   rst_n   : synchronous active-low reset
//   io_bus  : ripemd160_chain_core_if.slave (i_valid/i_ready/i_first/
//             i_last/i_block in, o_valid/o_digest out)
//
// Configuration macro
//   RIPEMD160_BYTE_ORDER_EN : when defined, message bytes enter MSB-first
//   (byte 0 at i_block[511:504]) and each digest word is byte-reversed so
//   o_digest reads as the usual hex digest string. When undefined, word Xj
//   is i_block[32j+31:32j] and o_digest carries the raw H words.
// -----------------------------------------------------------------------------
module ripemd160_chain_core #(
    parameter int UNROLL = 1
) (
    input  logic                   clk_p_i,
    input  logic                   rst_n,
    ripemd160_chain_core_if.slave  io_bus
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5 ||
          UNROLL == 8 || UNROLL == 10 || UNROLL == 16 || UNROLL == 20)) begin : g_bad_unroll
        $error("ripemd160_chain_core: UNROLL must be 1,2,4,5,8,10,16 or 20");
    end

    localparam logic [159:0] IV       = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [6:0]   STEP     = 7'(UNROLL);
    localparam logic [6:0]   LAST_CNT = 7'(80 - UNROLL);

    // Message word selection and rotate amounts, left (RL/SL) and right (RR/SR).
    localparam logic [3:0] RL [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15,
        7, 4,13, 1,10, 6,15, 3,12, 0, 9, 5, 2,14,11, 8,
        3,10,14, 4, 9,15, 8, 1, 2, 7, 0, 6,13,11, 5,12,
        1, 9,11,10, 0, 8,12, 4,13, 3, 7,15,14, 5, 6, 2,
        4, 0, 5, 9, 7,12, 2,10,14, 1, 3, 8,11, 6,15,13};
    localparam logic [3:0] RR [80] = '{
        5,14, 7, 0, 9, 2,11, 4,13, 6,15, 8, 1,10, 3,12,
        6,11, 3, 7, 0,13, 5,10,14,15, 8,12, 4, 9, 1, 2,
       15, 5, 1, 3, 7,14, 6, 9,11, 8,12, 2,10, 0, 4,13,
        8, 6, 4, 1, 3,11,15, 0, 5,12, 2,13, 9, 7,10,14,
       12,15,10, 4, 1, 5, 8, 7, 6, 2,13,14, 0, 3, 9,11};
    localparam logic [3:0] SL [80] = '{
       11,14,15,12, 5, 8, 7, 9,11,13,14,15, 6, 7, 9, 8,
        7, 6, 8,13,11, 9, 7,15, 7,12,15, 9,11, 7,13,12,
       11,13, 6, 7,14, 9,13,15,14, 8,13, 6, 5,12, 7, 5,
       11,12,14,15,14,15, 9, 8, 9,14, 5, 6, 8, 6, 5,12,
        9,15, 5,11, 6, 8,13,12, 5,12,13,14,11, 8, 5, 6};
    localparam logic [3:0] SR [80] = '{
        8, 9, 9,11,13,15,15, 5, 7, 7, 8,11,14,14,12, 6,
        9,13,15, 7,12, 8, 9,11, 7, 7,12, 7, 6,15,13,11,
        9, 7,15,11, 8, 6, 6,14,12,13, 5,14,13,13, 7, 5,
       15, 5, 8,11,14,14, 6,14, 6, 9,12, 9,12, 5,15, 8,
        8, 5,12, 9,12, 5,14, 6, 8,13, 6, 5,15,13,11,11};

    typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_ready;
    logic          w_accept;
    logic [6:0]    r_cnt;
    logic [511:0]  r_blk;
    logic          r_last;
    logic [159:0]  r_cv;
    logic [159:0]  r_h;
    logic [159:0]  r_l;
    logic [159:0]  r_r;
    logic          r_o_valid;
    logic [159:0]  r_o_digest;
    logic [511:0]  w_x_in;
    logic [159:0]  w_cv_in;
    logic [159:0]  w_l_nxt;
    logic [159:0]  w_r_nxt;
    logic [159:0]  w_h_new;
    logic [159:0]  w_dig_fmt;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [3:0] n);
        return (x << n) | (x >> (6'd32 - {2'b00, n}));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // g selects the boolean function of one 16-step group (0..4).
    function automatic logic [31:0] f_rnd(input logic [2:0] g, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
        case (g)
            3'd0:    return x ^ y ^ z;
            3'd1:    return (x & y) | (~x & z);
            3'd2:    return (x | ~y) ^ z;
            3'd3:    return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] k_left(input logic [2:0] g);
        case (g)
            3'd0:    return 32'h00000000;
            3'd1:    return 32'h5a827999;
            3'd2:    return 32'h6ed9eba1;
            3'd3:    return 32'h8f1bbcdc;
            default: return 32'ha953fd4e;
        endcase
    endfunction

    function automatic logic [31:0] k_right(input logic [2:0] g);
        case (g)
            3'd0:    return 32'h50a28be6;
            3'd1:    return 32'h5c4dd124;
            3'd2:    return 32'h6d703ef3;
            3'd3:    return 32'h7a6d76e9;
            default: return 32'h00000000;
        endcase
    endfunction

    // One step of the left line; state packed as {A,B,C,D,E}.
    function automatic logic [159:0] step_left(input logic [159:0] st, input logic [6:0] j,
                                               input logic [511:0] x);
        logic [31:0] a, b, c, d, e, t;
        {a, b, c, d, e} = st;
        t = rol(a + f_rnd(j[6:4], b, c, d) + x[32*RL[j] +: 32] + k_left(j[6:4]), SL[j]) + e;
        return {e, t, b, rol(c, 4'd10), d};
    endfunction

    // The right line walks the function groups in reverse order (f5..f1).
    function automatic logic [159:0] step_right(input logic [159:0] st, input logic [6:0] j,
                                                input logic [511:0] x);
        logic [31:0] a, b, c, d, e, t;
        {a, b, c, d, e} = st;
        t = rol(a + f_rnd(3'd4 - j[6:4], b, c, d) + x[32*RR[j] +: 32] + k_right(j[6:4]), SR[j]) + e;
        return {e, t, b, rol(c, 4'd10), d};
    endfunction

    // r_blk always holds words in Xj = r_blk[32j+31:32j] order, so any byte
    // reordering happens once on the way in and once on the way out.
`ifdef RIPEMD160_BYTE_ORDER_EN
    always_comb begin
        w_x_in = '0;
        for (int j = 0; j < 16; j++) begin
            w_x_in[32*j +: 32] = bswap32(io_bus.i_block[511-32*j -: 32]);
        end
    end

    always_comb begin
        w_dig_fmt = '0;
        for (int j = 0; j < 5; j++) begin
            w_dig_fmt[32*j +: 32] = bswap32(w_h_new[32*j +: 32]);
        end
    end
`else
    assign w_x_in    = io_bus.i_block;
    assign w_dig_fmt = w_h_new;
`endif

    assign w_cv_in  = io_bus.i_first ? IV : r_h;
    assign w_accept = w_ready && io_bus.i_valid;

    // Each unrolled step uses its own index so group boundaries inside one
    // cycle pick the right function and constant.
    always_comb begin
        w_l_nxt = r_l;
        w_r_nxt = r_r;
        for (int u = 0; u < UNROLL; u++) begin
            w_l_nxt = step_left(w_l_nxt, r_cnt + 7'(u), r_blk);
            w_r_nxt = step_right(w_r_nxt, r_cnt + 7'(u), r_blk);
        end
    end

    // Final combine: cv words rotate by one position against the line outputs.
    always_comb begin
        logic [31:0] h0, h1, h2, h3, h4;
        logic [31:0] al, bl, cl, dl, el;
        logic [31:0] ar, br, cr, dr, er;
        {h0, h1, h2, h3, h4} = r_cv;
        {al, bl, cl, dl, el} = r_l;
        {ar, br, cr, dr, er} = r_r;
        w_h_new = {h1 + cl + dr, h2 + dl + er, h3 + el + ar, h4 + al + br, h0 + bl + cr};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (io_bus.i_valid) w_state_nxt = ROUNDS;
            end
            ROUNDS:  if (r_cnt == LAST_CNT) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_p_i) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_blk      <= '0;
            r_last     <= 1'b0;
            r_cv       <= '0;
            r_h        <= IV;
            r_l        <= '0;
            r_r        <= '0;
            r_o_valid  <= 1'b0;
            r_o_digest <= '0;
        end else begin
            r_o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_blk  <= w_x_in;
                        r_last <= io_bus.i_last;
                        r_cv   <= w_cv_in;
                        r_l    <= w_cv_in;
                        r_r    <= w_cv_in;
                        r_cnt  <= '0;
                    end
                end
                ROUNDS: begin
                    r_l   <= w_l_nxt;
                    r_r   <= w_r_nxt;
                    r_cnt <= (r_cnt == LAST_CNT) ? 7'd0 : r_cnt + STEP;
                end
                DONE: begin
                    r_h <= w_h_new;
                    if (r_last) begin
                        r_o_valid  <= 1'b1;
                        r_o_digest <= w_dig_fmt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.i_ready  = w_ready;
    assign io_bus.o_valid  = r_o_valid;
    assign io_bus.o_digest = r_o_digest;

endmodule
